// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
//  Module   : spi_master
//  Purpose  : Single-clock SPI initiator for the 10-bit cmd/addr/data frame
//             protocol; shifts frames out MSB-first and collects read bytes.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_master #(
    parameter int FRAME_W = 10,
    parameter int DATA_W  = 8,
    parameter int RD_LAT  = 2,
    parameter int GAP     = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [FRAME_W-1:0] cmd_data,
    output logic               SS_n,
    output logic               MOSI,
    input  logic               MISO,
    output logic [DATA_W-1:0]  rd_data,
    output logic               rd_valid,
    output logic               busy
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SEL       = 3'd1,
        S_CMD       = 3'd2,
        S_SHIFT_OUT = 3'd3,
        S_HOLD      = 3'd4,
        S_WAIT_RD   = 3'd5,
        S_SHIFT_IN  = 3'd6,
        S_GAP       = 3'd7
    } state_t;

    localparam logic [1:0] c_CMD_RD_DATA = 2'b11;

    state_t              r_state;
    logic [FRAME_W-1:0]  r_frame;
    logic [3:0]          r_cnt;
    logic [DATA_W-1:0]   r_shift;
    logic                w_is_read;
    logic                w_end;

    assign w_is_read = (r_frame[FRAME_W-1 -: 2] == c_CMD_RD_DATA);
    // Both frame kinds release SS_n from the same place once their tail is done
    assign w_end     = ((r_state == S_HOLD) || (r_state == S_SHIFT_IN)) && (r_cnt == 4'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_frame   <= '0;
            r_cnt     <= 4'd0;
            r_shift   <= '0;
            SS_n      <= 1'b1;
            MOSI      <= 1'b0;
            cmd_ready <= 1'b0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        r_frame   <= cmd_data;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        SS_n      <= 1'b0;
                        MOSI      <= 1'b0;
                        r_state   <= S_SEL;
                    end
                end
                S_SEL: begin
                    MOSI    <= r_frame[FRAME_W-1];
                    r_cnt   <= 4'(FRAME_W - 1);
                    r_state <= S_CMD;
                end
                S_CMD: begin
                    MOSI    <= r_frame[r_cnt];
                    r_cnt   <= r_cnt - 4'd1;
                    r_state <= S_SHIFT_OUT;
                end
                S_SHIFT_OUT: begin
                    MOSI <= r_frame[r_cnt];
                    if (r_cnt == 4'd0) begin
                        if (w_is_read) begin
                            r_cnt   <= 4'(RD_LAT - 1);
                            r_state <= S_WAIT_RD;
                        end else begin
                            r_cnt   <= 4'd1;
                            r_state <= S_HOLD;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_HOLD: begin
                    MOSI  <= 1'b0;
                    r_cnt <= r_cnt - 4'd1;
                end
                S_WAIT_RD: begin
                    MOSI <= 1'b0;
                    if (r_cnt == 4'd0) begin
                        r_cnt   <= 4'(DATA_W);
                        r_state <= S_SHIFT_IN;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_SHIFT_IN: begin
                    // MISO is only looked at here, so X elsewhere never enters r_shift
                    if (r_cnt != 4'd0) begin
                        r_shift <= {r_shift[DATA_W-2:0], MISO};
                        r_cnt   <= r_cnt - 4'd1;
                    end else begin
                        rd_data  <= r_shift;
                        rd_valid <= 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_cnt == 4'd0) begin
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // With GAP=1 ready rises with SS_n so a back-to-back frame sees one high cycle
            if (w_end) begin
                SS_n <= 1'b1;
                MOSI <= 1'b0;
                if (GAP <= 1) begin
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    r_state   <= S_IDLE;
                end else begin
                    r_cnt   <= 4'(GAP - 2);
                    r_state <= S_GAP;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_master
//  Purpose  : Self-checking bench for spi_master with a RAM-slave model that
//             predicts every output cycle from the frame timing rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_master;

    localparam int RD_LAT = 2;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [9:0] cmd_data  = '0;
    logic       MISO      = 1'b0;
    logic       cmd_ready, SS_n, MOSI, rd_valid, busy;
    logic [7:0] rd_data;

    int checks   = 0;
    int failures = 0;

    // Slave RAM model and expected read-data register
    logic [7:0] mem [256];
    logic [7:0] m_wr_addr = '0;
    logic [7:0] m_rd_addr = '0;
    logic [7:0] m_rd      = '0;

    spi_master #(.FRAME_W(10), .DATA_W(8), .RD_LAT(RD_LAT), .GAP(1)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_data(cmd_data), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
        .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic exp_mosi(input logic [9:0] f, input int k);
        if (k == 1)               return f[9];
        else if (k >= 2 && k <= 11) return f[11-k];
        else                      return 1'b0;
    endfunction

    task automatic model_update(input logic [9:0] f, input logic [7:0] resp);
        case (f[9:8])
            2'b00: m_wr_addr = f[7:0];
            2'b01: mem[m_wr_addr] = f[7:0];
            2'b10: m_rd_addr = f[7:0];
            default: m_rd = resp;
        endcase
    endtask

    task automatic wait_ready();
        int guard = 0;
        while (cmd_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_timeout got=%b exp=1", cmd_ready);
        end
    endtask

    // Sends one frame starting from a negedge; returns at the negedge after the
    // edge that raised cmd_ready again, so a following call goes back-to-back.
    task automatic send_frame(input logic [9:0] f, input bit xmiso);
        bit         rd;
        int         n, b;
        logic [7:0] resp;
        logic [9:0] rx;
        logic       e_ss, e_mo, e_rv;
        logic [7:0] e_rd;
        rd   = (f[9:8] == 2'b11);
        n    = rd ? 20 + RD_LAT : 13;
        resp = mem[m_rd_addr];
        rx   = '0;
        wait_ready();
        cmd_valid = 1'b1;
        cmd_data  = f;
        for (int k = 0; k <= n; k++) begin
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
            cmd_data  = 10'($urandom);
            b = k + 1 - (12 + RD_LAT);
            if (rd && b >= 0 && b < 8) MISO = resp[7-b];
            else MISO = xmiso ? 1'bx : 1'($urandom);
            @(negedge clk);
            e_ss = (k < n) ? 1'b0 : 1'b1;
            e_mo = exp_mosi(f, k);
            e_rv = (rd && k == n);
            e_rd = (rd && k == n) ? resp : m_rd;
            if (k >= 2 && k <= 11) rx = {rx[8:0], MOSI};
            checks += 6;
            if (SS_n !== e_ss) begin failures++; $display("FAIL ss_n f=%h k=%0d got=%b exp=%b", f, k, SS_n, e_ss); end
            if (MOSI !== e_mo) begin failures++; $display("FAIL mosi f=%h k=%0d got=%b exp=%b", f, k, MOSI, e_mo); end
            if (busy !== (k < n)) begin failures++; $display("FAIL busy f=%h k=%0d got=%b exp=%b", f, k, busy, (k < n)); end
            if (cmd_ready !== (k == n)) begin failures++; $display("FAIL cmd_ready f=%h k=%0d got=%b exp=%b", f, k, cmd_ready, (k == n)); end
            if (rd_valid !== e_rv) begin failures++; $display("FAIL rd_valid f=%h k=%0d got=%b exp=%b", f, k, rd_valid, e_rv); end
            if (rd_data !== e_rd) begin failures++; $display("FAIL rd_data f=%h k=%0d got=%h exp=%h", f, k, rd_data, e_rd); end
        end
        checks++;
        if (rx !== f) begin failures++; $display("FAIL rx_frame got=%h exp=%h", rx, f); end
        model_update(f, resp);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks += 6;
        if (SS_n !== 1'b1)      begin failures++; $display("FAIL rst_ss_n got=%b exp=1", SS_n); end
        if (MOSI !== 1'b0)      begin failures++; $display("FAIL rst_mosi got=%b exp=0", MOSI); end
        if (cmd_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", cmd_ready); end
        if (rd_data !== 8'h00)  begin failures++; $display("FAIL rst_rd_data got=%h exp=00", rd_data); end
        if (rd_valid !== 1'b0)  begin failures++; $display("FAIL rst_rd_valid got=%b exp=0", rd_valid); end
        if (busy !== 1'b0)      begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        rst_n = 1'b1;
        @(negedge clk);
        checks += 2;
        if (cmd_ready !== 1'b1) begin failures++; $display("FAIL post_rst_ready got=%b exp=1", cmd_ready); end
        if (SS_n !== 1'b1)      begin failures++; $display("FAIL post_rst_ss_n got=%b exp=1", SS_n); end
    endtask

    task automatic test_write_addr();
        send_frame(10'b00_1010_0101, 1'b0);
    endtask

    task automatic test_read_data();
        mem[m_rd_addr] = 8'h3C;
        send_frame(10'b11_0000_0000, 1'b0);
        checks++;
        if (rd_data !== 8'h3C) begin failures++; $display("FAIL t2_rd_data got=%h exp=3c", rd_data); end
    endtask

    task automatic test_back_to_back();
        send_frame(10'h010, 1'b0);
        send_frame(10'h1AB, 1'b0);
        send_frame(10'h210, 1'b0);
        send_frame(10'h300, 1'b0);
        checks++;
        if (rd_data !== 8'hAB) begin failures++; $display("FAIL t3_rd_data got=%h exp=ab", rd_data); end
    endtask

    task automatic test_random();
        logic [9:0] f;
        for (int i = 0; i < 24; i++) begin
            f = {2'($urandom_range(0, 3)), 8'($urandom_range(0, 7))};
            send_frame(f, 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic test_held_valid();
        logic [9:0] d  [56];
        logic       rb [56];
        logic       ss [56];
        logic       mo [56];
        logic       rv [56];
        bit         rv_seen;
        wait_ready();
        for (int c = 0; c < 56; c++) begin
            if (c < 40) begin
                d[c]      = {2'($urandom_range(0, 2)), 8'($urandom)};
                cmd_valid = 1'b1;
                cmd_data  = d[c];
            end else begin
                d[c]      = '0;
                cmd_valid = 1'b0;
            end
            rb[c] = cmd_ready;
            @(posedge clk);
            @(negedge clk);
            ss[c] = SS_n;
            mo[c] = MOSI;
            rv[c] = rd_valid;
        end
        rv_seen = 1'b0;
        for (int c = 0; c < 56; c++) begin
            checks++;
            if (rb[c] !== ((c % 14 == 0) || c >= 42)) begin
                failures++; $display("FAIL t4_ready c=%0d got=%b exp=%b", c, rb[c], ((c % 14 == 0) || c >= 42));
            end
            if (rv[c] !== 1'b0) rv_seen = 1'b1;
        end
        for (int a = 0; a < 40; a += 14) begin
            for (int k = 0; k < 14; k++) begin
                checks += 2;
                if (ss[a+k] !== (k == 13)) begin failures++; $display("FAIL t4_ss_n a=%0d k=%0d got=%b exp=%b", a, k, ss[a+k], (k == 13)); end
                if (mo[a+k] !== exp_mosi(d[a], k)) begin failures++; $display("FAIL t4_mosi a=%0d k=%0d got=%b exp=%b", a, k, mo[a+k], exp_mosi(d[a], k)); end
            end
            model_update(d[a], 8'h00);
        end
        checks++;
        if (rv_seen) begin failures++; $display("FAIL t4_rd_valid got=1 exp=0"); end
    endtask

    task automatic test_reset_mid();
        bit rv_seen = 1'b0;
        mem[m_rd_addr] = 8'h5A;
        wait_ready();
        cmd_valid = 1'b1;
        cmd_data  = 10'h300;
        @(posedge clk);                 // E0
        #1 cmd_valid = 1'b0;
        repeat (5) @(posedge clk);      // E1..E5
        #1 rst_n = 1'b0;
        @(posedge clk);                 // E6 under reset
        @(negedge clk);
        checks += 4;
        if (SS_n !== 1'b1)      begin failures++; $display("FAIL t5_ss_n got=%b exp=1", SS_n); end
        if (busy !== 1'b0)      begin failures++; $display("FAIL t5_busy got=%b exp=0", busy); end
        if (cmd_ready !== 1'b0) begin failures++; $display("FAIL t5_ready got=%b exp=0", cmd_ready); end
        if (rd_data !== 8'h00)  begin failures++; $display("FAIL t5_rd_data got=%h exp=00", rd_data); end
        if (rd_valid !== 1'b0) rv_seen = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        m_rd  = 8'h00;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin failures++; $display("FAIL t5_ready_after got=%b exp=1", cmd_ready); end
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (rd_valid !== 1'b0 || SS_n !== 1'b1) rv_seen = 1'b1;
        end
        checks++;
        if (rv_seen) begin failures++; $display("FAIL t5_activity got=1 exp=0"); end
        send_frame(10'h300, 1'b0);
    endtask

    task automatic test_miso_x();
        for (int i = 0; i < 3; i++) begin
            send_frame({2'b10, 8'($urandom)}, 1'b1);
            send_frame(10'h300, 1'b1);
            checks++;
            if ($isunknown(rd_data)) begin failures++; $display("FAIL t6_rd_data_x got=%h exp=%h", rd_data, m_rd); end
        end
        MISO = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        test_reset();
        test_write_addr();
        test_read_data();
        test_back_to_back();
        test_held_valid();
        test_random();
        test_reset_mid();
        test_miso_x();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog timeout");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
